seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Time-multiplexed driver for a common-anode bank of seven-segment digits. It generalises the single-digit BCD decoder to NUM_DIGITS digits, a runtime BCD/hex glyph mode and a tear-free value-update handshake. The block sits between the datapath that produces the displayed number and the board's segment and anode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000, clock cycles each digit stays lit; legal minimum 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- value_i  in  4*NUM_DIGITS  packed nibbles; digit i is value_i[4i+3:4i]; digit 0 is least significant.
- value_valid  in  1  value_i is offered this cycle.
- value_ready  out  1  block can accept a new value; equals ~pending.
- hex_mode  in  1  0 = BCD (nibbles 10–15 blank), 1 = hex glyphs.
- segments  out  7  {g,f,e,d,c,b,a}, active low, registered.
- anodes  out  NUM_DIGITS  one-hot-low digit enable, registered; bit i drives digit i.

## Operation
- Prescaler `div_cnt` counts 0..SCAN_DIV-1 and wraps. Terminal count is `div_cnt == SCAN_DIV-1`.
- Digit index `idx` increments on terminal count and wraps from NUM_DIGITS-1 to 0.
- Frame end is terminal count with `idx == NUM_DIGITS-1`.
- Registers:
  - `shadow`: captures value_i on an accept (value_valid && value_ready); sets `pending`.
  - `disp`: copies `shadow` and clears `pending` at frame end, only if `pending` is 1.
  - An accept is impossible while `pending` is 1, so accept and commit never collide.
  - With `pending` 0 at frame end, the display holds. An accept on that same cycle commits at the next frame end.
  - value_valid is ignored when value_ready is 0. The source holds the value until accepted.
- Glyphs, active low {g..a}:
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001
  - 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000
  - hex_mode=1: A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110
  - hex_mode=0, nibble ≥10: blank 1111111.
- Output registers load every cycle:
  - anodes <= ~(1 << idx_next)
  - segments <= glyph(disp nibble at idx_next), or blank if that digit is blanked.
  - This keeps segment and anode changes coincident, with no ghosting cycle.
- hex_mode is sampled directly into the output path. A change takes effect on the next cycle.

## Timing
- Reset, while rst_n is low at a clock edge:
  - div_cnt, idx, shadow, disp, pending all clear to 0.
  - segments = 7'b1111111; anodes = all ones; value_ready = 1.
- First cycle after reset release: anodes = ~1 (digit 0 lit), segments = 7'b1000000.
- Each digit is lit for exactly SCAN_DIV cycles. Frame period is NUM_DIGITS*SCAN_DIV cycles.
- Accept to first changed glyph: worst case NUM_DIGITS*SCAN_DIV + 1 cycles; best case 2 cycles (accept at frame end − 1).
- value_ready is low from the cycle after accept through the frame-end cycle. It is high again on the next cycle.
- Reset asserted mid-frame or with an update pending: the pending value is discarded and outputs blank on the next edge.
- NUM_DIGITS = 1: idx is constant 0 and every terminal count is a frame end.

## Configuration
- SEVEN_SEG_LZB_EN defined: leading-zero blanking is enabled.
  - Digit i > 0 is blanked when disp nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - Its anode still scans low in its slot, with segments 1111111.
- SEVEN_SEG_LZB_EN undefined: all digits always show their glyph. No blanking logic is instantiated.

## Test plan
- Reset check, NUM_DIGITS=4, SCAN_DIV=4: hold rst_n low 3 cycles → segments 1111111, anodes 1111, value_ready 1. Release → next cycle anodes 1110, segments 1000000.
- Scan cadence: idle after reset → anodes step 1110→1101→1011→0111→1110, each held exactly 4 cycles.
- Update handshake: accept 16'h1234 mid-frame → value_ready 0 until frame end. Next frame shows digit0 0011001, digit1 0110000, digit2 0100100, digit3 1111001. A second valid while not ready is ignored.
- Hex mode: disp 16'hABCD. hex_mode=1 → digit0 glyph 0100001 (d). hex_mode=0 → digit0 1111111. The switch takes effect one cycle after toggle.
- Leading-zero blanking, macro defined: value 16'h0070 → digits 3 and 2 blank, digit1 1111000, digit0 1000000. Macro undefined → digits 3 and 2 show 1000000.
- Reset mid-update: accept 16'h9999, then assert rst_n low before frame end → after release, value_ready 1 and digit0 shows 1000000, not 0010000.

Source files
------------

// File: rtl/seven_seg_scan_driver_if.sv
// Value-update handshake between the number-producing datapath and the seven-segment scan driver.
// The source holds value_i stable with value_valid high until value_ready accepts it.
interface seven_seg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic [4*NUM_DIGITS-1:0] value_i;
  logic                    value_valid;
  logic                    value_ready;

  modport master (
    output value_i,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_i,
    input  value_valid,
    output value_ready
  );

endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with tear-free value updates.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_driver_if.slave value_if,
  input  logic                  hex_mode,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] anodes
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ValW = 4 * NUM_DIGITS;

  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
  localparam logic [6:0]      SegBlank = 7'b1111111;

  logic [DivW-1:0]       r_div_cnt;
  logic [IdxW-1:0]       r_idx;
  logic [ValW-1:0]       r_shadow;
  logic [ValW-1:0]       r_disp;
  logic                  r_pending;
  logic [6:0]            r_segments;
  logic [NUM_DIGITS-1:0] r_anodes;

  logic            w_tc;
  logic            w_frame_end;
  logic            w_accept;
  logic            w_commit;
  logic [DivW-1:0] w_div_next;
  logic [IdxW-1:0] w_idx_next;
  logic [3:0]      w_nib;
  logic            w_blank;

  function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = hex ? 7'b0001000 : SegBlank;
      4'hB: seg = hex ? 7'b0000011 : SegBlank;
      4'hC: seg = hex ? 7'b1000110 : SegBlank;
      4'hD: seg = hex ? 7'b0100001 : SegBlank;
      4'hE: seg = hex ? 7'b0000110 : SegBlank;
      4'hF: seg = hex ? 7'b0001110 : SegBlank;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  always_comb begin
    w_tc        = (r_div_cnt == DivLast);
    w_frame_end = w_tc && (r_idx == IdxLast);
    w_div_next  = w_tc ? '0 : r_div_cnt + DivW'(1);
    w_idx_next  = r_idx;
    if (w_tc) begin
      w_idx_next = (r_idx == IdxLast) ? '0 : r_idx + IdxW'(1);
    end
    // pending gates both sides, so an accept and a commit can never land on the same edge
    w_accept = value_if.value_valid && !r_pending;
    w_commit = w_frame_end && r_pending;
  end

  assign value_if.value_ready = ~r_pending;

`ifdef SEVEN_SEG_LZB_EN
  // w_lz[i] is set when nibbles i..NUM_DIGITS-1 of the displayed value are all zero
  logic [NUM_DIGITS-1:0] w_lz;

  always_comb begin
    w_lz = '0;
    w_lz[NUM_DIGITS-1] = (r_disp[ValW-1 -: 4] == 4'h0);
    for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] && (r_disp[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    w_nib   = r_disp[3:0];
    w_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IdxW'(i) == w_idx_next) begin
        w_nib   = r_disp[4*i +: 4];
        w_blank = (i != 0) && w_lz[i];
      end
    end
  end
`else
  always_comb begin
    w_nib   = r_disp[3:0];
    w_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IdxW'(i) == w_idx_next) begin
        w_nib = r_disp[4*i +: 4];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_disp     <= '0;
      r_pending  <= 1'b0;
      r_segments <= SegBlank;
      r_anodes   <= '1;
    end else begin
      r_div_cnt <= w_div_next;
      r_idx     <= w_idx_next;
      if (w_accept) begin
        r_shadow  <= value_if.value_i;
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_disp    <= r_shadow;
        r_pending <= 1'b0;
      end
      // anode and segment registers both follow idx_next so they switch on the same edge
      r_anodes   <= ~(NUM_DIGITS'(1) << w_idx_next);
      r_segments <= w_blank ? SegBlank : glyph(w_nib, hex_mode);
    end
  end

  assign segments = r_segments;
  assign anodes   = r_anodes;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed scoreboard bench for seven_seg_scan_driver (NUM_DIGITS=4, SCAN_DIV=4).
// Expected glyph/anode pairs are queued per edge and popped when the DUT output is sampled.
module tb_seven_seg_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
`ifdef SEVEN_SEG_LZB_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hex_mode = 1'b0;
  logic [6:0] segments;
  logic [3:0] anodes;

  seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) u_if ();

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_if(u_if),
    .hex_mode(hex_mode),
    .segments(segments),
    .anodes  (anodes)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          edge_k = 0;
  logic [10:0] exp_q[$];

  function automatic logic [6:0] ref_glyph(input logic [3:0] nib, input logic hex);
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return hex ? 7'b0001000 : 7'b1111111;
      4'hB: return hex ? 7'b0000011 : 7'b1111111;
      4'hC: return hex ? 7'b1000110 : 7'b1111111;
      4'hD: return hex ? 7'b0100001 : 7'b1111111;
      4'hE: return hex ? 7'b0000110 : 7'b1111111;
      default: return hex ? 7'b0001110 : 7'b1111111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edge_k++;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_k, obs, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    logic [10:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %b_%b", tag, anodes, segments);
    end else begin
      e = exp_q.pop_front();
      assert ({anodes, segments} === e) else begin
        n_fail++;
        $error("FAIL %s @edge %0d: observed an=%b seg=%b expected an=%b seg=%b",
               tag, edge_k, anodes, segments, e[10:7], e[6:0]);
      end
    end
  endtask

  // One edge of the scan: digit slot derived from edges since reset release, glyph from the
  // value the display is expected to hold during that edge.
  task automatic scan_edge(input string tag, input logic [15:0] val);
    int         k;
    int         d;
    logic [3:0] nib;
    logic [3:0] an;
    logic [6:0] seg;
    logic [15:0] upper;
    k     = edge_k + 1;
    d     = (k / SD) % ND;
    nib   = val[4*d +: 4];
    upper = val >> (4 * d);
    an    = ~(4'b0001 << d);
    seg   = ref_glyph(nib, hex_mode);
    if (Lzb && d > 0 && upper == 16'h0) seg = 7'b1111111;
    exp_q.push_back({an, seg});
    step();
    compare_out(tag);
  endtask

  initial begin
    u_if.value_i     = '0;
    u_if.value_valid = 1'b0;

    // Reset held for three edges
    rst_n = 1'b0;
    repeat (3) step();
    exp_q.push_back({4'b1111, 7'b1111111});
    compare_out("reset_out");
    check_bit("reset_ready", u_if.value_ready, 1'b1);

    rst_n  = 1'b1;
    edge_k = 0;
    for (int i = 0; i < 16; i++) scan_edge("idle_scan", 16'h0000);

    // Accept 1234; a second valid while not ready must be ignored
    u_if.value_i     = 16'h1234;
    u_if.value_valid = 1'b1;
    scan_edge("accept_1234", 16'h0000);
    check_bit("ready_after_accept", u_if.value_ready, 1'b0);
    u_if.value_i = 16'h5555;
    scan_edge("ignored_valid", 16'h0000);
    u_if.value_valid = 1'b0;
    u_if.value_i     = '0;
    while (edge_k < 32) begin
      scan_edge("wait_commit", 16'h0000);
      check_bit("ready_until_frame_end", u_if.value_ready, edge_k == 32);
    end
    while (edge_k < 48) scan_edge("show_1234", 16'h1234);

    // Hex mode with ABCD
    hex_mode         = 1'b1;
    u_if.value_i     = 16'hABCD;
    u_if.value_valid = 1'b1;
    scan_edge("accept_abcd", 16'h1234);
    u_if.value_valid = 1'b0;
    while (edge_k < 64) scan_edge("wait_abcd", 16'h1234);
    scan_edge("hex_d", 16'hABCD);
    hex_mode = 1'b0;
    scan_edge("bcd_blank", 16'hABCD);
    hex_mode = 1'b1;
    scan_edge("hex_d_again", 16'hABCD);
    while (edge_k < 80) scan_edge("hex_scan", 16'hABCD);

    // Leading zeros
    u_if.value_i     = 16'h0070;
    u_if.value_valid = 1'b1;
    scan_edge("accept_0070", 16'hABCD);
    u_if.value_valid = 1'b0;
    while (edge_k < 96) scan_edge("wait_0070", 16'hABCD);
    while (edge_k < 112) scan_edge("show_0070", 16'h0070);

    // Reset with an update pending discards it
    u_if.value_i     = 16'h9999;
    u_if.value_valid = 1'b1;
    scan_edge("accept_9999", 16'h0070);
    u_if.value_valid = 1'b0;
    check_bit("ready_9999_pending", u_if.value_ready, 1'b0);
    repeat (3) scan_edge("pre_reset", 16'h0070);
    rst_n = 1'b0;
    step();
    exp_q.push_back({4'b1111, 7'b1111111});
    compare_out("midframe_reset_out");
    check_bit("midframe_reset_ready", u_if.value_ready, 1'b1);
    step();
    rst_n  = 1'b1;
    edge_k = 0;
    for (int i = 0; i < 20; i++) begin
      scan_edge("post_reset", 16'h0000);
      check_bit("post_reset_ready", u_if.value_ready, 1'b1);
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
